// File: rtl/harq_sched_pkg.sv
// Shared encodings for the HARQ combine scheduler: buffer states, FSM states, buffer ids.
package harq_sched_pkg;

  typedef enum logic [1:0] {
    BUF_FREE = 2'd0,
    BUF_COMB = 2'd1,
    BUF_FULL = 2'd2,
    BUF_SEND = 2'd3
  } buf_state_t;

  typedef enum logic [2:0] {
    C_IDLE      = 3'd0,
    C_SELECT    = 3'd1,
    C_ISSUE     = 3'd2,
    C_WAIT_COMB = 3'd3,
    C_DRAIN     = 3'd4,
    C_DONE      = 3'd5
  } comb_state_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } send_state_t;

  localparam logic PING = 1'b0;
  localparam logic PONG = 1'b1;

  localparam int DEF_NUM_USERS = 8;
  localparam int DEF_NCB_W     = 16;

endpackage

// File: rtl/harq_lowest_set_pick.sv
// Combinational priority encoder: index of the lowest set bit of mask, vld when any bit is set.
module harq_lowest_set_pick #(
  parameter int N     = 8,
  parameter int IDX_W = 4
) (
  input  logic [N-1:0]     mask,
  output logic [IDX_W-1:0] idx,
  output logic             vld
);

  always_comb begin
    idx = '0;
    vld = |mask;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/harq_comb_scheduler.sv
// Per-slot HARQ combine scheduler with ping/pong buffer ownership; first combine request 2 cycles
// after slot start, stalls in SELECT while no buffer is free. Optional watchdog: HARQ_SCHED_WATCHDOG_EN.
module harq_comb_scheduler
  import harq_sched_pkg::*;
#(
  parameter int NUM_USERS = DEF_NUM_USERS,
  parameter int NCB_W     = DEF_NCB_W,
  parameter int UIDX_W    = 4
`ifdef HARQ_SCHED_WATCHDOG_EN
  ,parameter int TIMEOUT_CYC = 65535
`endif
) (
  input  logic                       i_core_clk,
  input  logic                       i_rx_rstn,
  input  logic                       i_rdm_slot_start,
  input  logic [NUM_USERS-1:0]       i_user_mask,
  input  logic [NUM_USERS*NCB_W-1:0] i_users_ncb,
  output logic                       o_combine_request,
  output logic [UIDX_W-1:0]          o_combine_user_index,
  output logic                       o_combine_buf_sel,
  input  logic                       i_combine_comp,
  output logic                       o_sendharq_request,
  output logic                       o_sendharq_buf_sel,
  output logic [NCB_W-1:0]           o_sendharq_ncb,
  input  logic                       i_sendharq_comp,
  output logic                       o_busy,
  output logic                       o_slot_done
`ifdef HARQ_SCHED_WATCHDOG_EN
  ,output logic                      o_timeout
`endif
);

  comb_state_t          c_state, c_next;
  send_state_t          s_state, s_next;
  buf_state_t           buf_st  [2];
  logic [UIDX_W-1:0]    buf_tag [2];
  logic [NUM_USERS-1:0] pending, ncb_nz;
  logic [UIDX_W-1:0]    pick_idx, cur_user;
  logic                 pick_vld, cur_buf, send_buf;
  logic                 free_vld, free_sel, any_full, full_sel;
  logic                 comb_to, send_to, comb_done, send_done;

  always_comb begin
    ncb_nz = '0;
    for (int k = 0; k < NUM_USERS; k++) ncb_nz[k] = |i_users_ncb[k*NCB_W +: NCB_W];
  end

  harq_lowest_set_pick #(.N(NUM_USERS), .IDX_W(UIDX_W)) u_pick (
    .mask (pending),
    .idx  (pick_idx),
    .vld  (pick_vld)
  );

  assign free_vld  = (buf_st[PING] == BUF_FREE) || (buf_st[PONG] == BUF_FREE);
  assign free_sel  = (buf_st[PING] == BUF_FREE) ? PING : PONG;
  assign any_full  = (buf_st[PING] == BUF_FULL) || (buf_st[PONG] == BUF_FULL);
  assign full_sel  = (buf_st[PING] == BUF_FULL) ? PING : PONG;
  assign comb_done = (c_state == C_WAIT_COMB) && (i_combine_comp || comb_to);
  assign send_done = (s_state == S_WAIT) && (i_sendharq_comp || send_to);

`ifdef HARQ_SCHED_WATCHDOG_EN
  logic [15:0] comb_cnt, send_cnt;

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      comb_cnt <= '0;
      send_cnt <= '0;
    end else begin
      comb_cnt <= (c_state == C_WAIT_COMB && !comb_done) ? comb_cnt + 16'd1 : '0;
      send_cnt <= (s_state == S_WAIT && !send_done) ? send_cnt + 16'd1 : '0;
    end
  end

  assign comb_to   = (c_state == C_WAIT_COMB) && !i_combine_comp && (comb_cnt == 16'(TIMEOUT_CYC - 1));
  assign send_to   = (s_state == S_WAIT) && !i_sendharq_comp && (send_cnt == 16'(TIMEOUT_CYC - 1));
  assign o_timeout = comb_to | send_to;
`else
  assign comb_to = 1'b0;
  assign send_to = 1'b0;
`endif

  always_comb begin
    c_next = c_state;
    case (c_state)
      C_IDLE:      if (i_rdm_slot_start) c_next = C_SELECT;
      C_SELECT:    if (!pick_vld) c_next = C_DRAIN;
                   else if (free_vld) c_next = C_ISSUE;
      C_ISSUE:     c_next = C_WAIT_COMB;
      C_WAIT_COMB: if (comb_done) c_next = C_SELECT;
      C_DRAIN:     if (buf_st[PING] == BUF_FREE && buf_st[PONG] == BUF_FREE) c_next = C_DONE;
      C_DONE:      c_next = C_IDLE;
      default:     c_next = C_IDLE;
    endcase
  end

  always_comb begin
    s_next = s_state;
    case (s_state)
      S_IDLE:  if (any_full) s_next = S_ISSUE;
      S_ISSUE: s_next = S_WAIT;
      S_WAIT:  if (send_done) s_next = S_IDLE;
      default: s_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      c_state  <= C_IDLE;
      s_state  <= S_IDLE;
      pending  <= '0;
      cur_user <= '0;
      cur_buf  <= PING;
      send_buf <= PING;
    end else begin
      c_state <= c_next;
      s_state <= s_next;
      // Zero-Ncb users have nothing to combine, so they never enter pending.
      if (c_state == C_IDLE && i_rdm_slot_start) pending <= i_user_mask & ncb_nz;
      if (c_state == C_SELECT && pick_vld && free_vld) begin
        cur_user <= pick_idx;
        cur_buf  <= free_sel;
      end
      if (c_state == C_ISSUE) pending <= pending & ~(NUM_USERS'(1) << cur_user);
      if (s_state == S_IDLE && any_full) send_buf <= full_sel;
    end
  end

  // Combine and send always own different buffers, so their updates never collide.
  always_ff @(posedge i_core_clk or negedge i_rx_rstn) begin
    if (!i_rx_rstn) begin
      for (int b = 0; b < 2; b++) begin
        buf_st[b]  <= BUF_FREE;
        buf_tag[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (c_state == C_ISSUE && cur_buf == 1'(b)) begin
          buf_st[b]  <= BUF_COMB;
          buf_tag[b] <= cur_user;
        end else if (c_state == C_WAIT_COMB && cur_buf == 1'(b) && i_combine_comp) begin
          buf_st[b] <= BUF_FULL;
        end else if (c_state == C_WAIT_COMB && cur_buf == 1'(b) && comb_to) begin
          buf_st[b] <= BUF_FREE;
        end
        if (s_state == S_ISSUE && send_buf == 1'(b)) buf_st[b] <= BUF_SEND;
        else if (send_done && send_buf == 1'(b)) buf_st[b] <= BUF_FREE;
      end
    end
  end

  assign o_combine_request    = (c_state == C_ISSUE);
  assign o_combine_user_index = cur_user;
  assign o_combine_buf_sel    = cur_buf;
  assign o_sendharq_request   = (s_state == S_ISSUE);
  assign o_sendharq_buf_sel   = send_buf;
  assign o_sendharq_ncb       = (s_state != S_IDLE) ?
                                i_users_ncb[int'(buf_tag[send_buf])*NCB_W +: NCB_W] : '0;
  assign o_busy               = (c_state != C_IDLE);
  assign o_slot_done          = (c_state == C_DONE);

endmodule
